// File: rtl/disp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | disp_pkg : shared types, constants and segment encoding for the display    |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        FRAC   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    // Non-decimal code routed through the digit encoder to draw the sign dash.
    localparam logic [3:0] DIGIT_MINUS = 4'hA;

    localparam logic [2:0] POS_SIGN   = 3'd5;
    localparam logic [2:0] POS_HUND   = 3'd4;
    localparam logic [2:0] POS_TENS   = 3'd3;
    localparam logic [2:0] POS_UNITS  = 3'd2;
    localparam logic [2:0] POS_TENTH  = 3'd1;
    localparam logic [2:0] POS_HUNDTH = 3'd0;

    localparam int NUM_STEPS = 9;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] w_seg;
        case (digit)
            4'd0:        w_seg = 7'b1000000;
            4'd1:        w_seg = 7'b1111001;
            4'd2:        w_seg = 7'b0100100;
            4'd3:        w_seg = 7'b0110000;
            4'd4:        w_seg = 7'b0011001;
            4'd5:        w_seg = 7'b0010010;
            4'd6:        w_seg = 7'b0000010;
            4'd7:        w_seg = 7'b1111000;
            4'd8:        w_seg = 7'b0000000;
            4'd9:        w_seg = 7'b0010000;
            DIGIT_MINUS: w_seg = SEG_MINUS;
            default:     w_seg = SEG_BLANK;
        endcase
        return w_seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_digit_enc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg_digit_enc : combinational digit + blank flag to active-low gfedcba      |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
module seg_digit_enc
    import disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            seg = seg_encode(digit);
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_display_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg_display_ctrl : Q9.6 sign-magnitude to 6-digit multiplexed 7-seg display |
// | Option macro     : SEG_LEADING_ZERO_BLANK_EN (blank leading hundreds/tens)  |
// | Revision         : 1.0                                                      |
// +----------------------------------------------------------------------------+
module seg_display_ctrl
    import disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        busy,
    output logic [5:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int                 c_DIV_W     = $clog2(SCAN_DIV);
    localparam logic [c_DIV_W-1:0] c_DIV_MAX   = c_DIV_W'(SCAN_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE   = c_DIV_W'(1);
    localparam logic [3:0]         c_LAST_STEP = 4'(NUM_STEPS - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic        w_accept;

    logic        r_neg;
    logic [8:0]  r_shift;
    logic [5:0]  r_frac;
    logic [11:0] r_bcd;
    logic [3:0]  r_step;
    logic [3:0]  r_tenth;
    logic [3:0]  r_hundth;
    logic [11:0] w_bcd_adj;
    logic [6:0]  w_frac_q;

    logic        r_disp_neg;
    logic [3:0]  r_disp_hund;
    logic [3:0]  r_disp_tens;
    logic [3:0]  r_disp_units;
    logic [3:0]  r_disp_tenth;
    logic [3:0]  r_disp_hundth;
    logic        r_disp_blank_h;
    logic        r_disp_blank_t;

    logic        w_dn_neg;
    logic [3:0]  w_dn_hund;
    logic [3:0]  w_dn_tens;
    logic [3:0]  w_dn_units;
    logic [3:0]  w_dn_tenth;
    logic [3:0]  w_dn_hundth;
    logic        w_dn_blank_h;
    logic        w_dn_blank_t;

    logic [c_DIV_W-1:0] r_div;
    logic               w_wrap;
    logic [2:0]         r_pos;
    logic [2:0]         w_pos_next;
    logic [3:0]         w_mux_digit;
    logic               w_mux_blank;
    logic [6:0]         w_enc_seg;
    logic [5:0]         r_an;
    logic [6:0]         r_seg;
    logic               r_dp;

    assign in_ready = (r_state == IDLE);
    assign busy     = ~in_ready;
    assign w_accept = in_ready & in_valid;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = CONV;
            CONV:    if (r_step == c_LAST_STEP) w_state_next = FRAC;
            FRAC:    w_state_next = COMMIT;
            COMMIT:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------- conversion
    always_comb begin
        w_bcd_adj = '0;
        for (int i = 0; i < 3; i++) begin
            w_bcd_adj[i*4 +: 4] = (r_bcd[i*4 +: 4] >= 4'd5) ? (r_bcd[i*4 +: 4] + 4'd3)
                                                            : r_bcd[i*4 +: 4];
        end
    end

    // Fraction in hundredths: (f * 100) / 64, truncated; max 98.
    assign w_frac_q = 7'(({7'd0, r_frac} * 13'd100) >> 6);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg    <= 1'b0;
            r_shift  <= '0;
            r_frac   <= '0;
            r_bcd    <= '0;
            r_step   <= '0;
            r_tenth  <= '0;
            r_hundth <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_neg   <= in_data[15] & (|in_data[14:0]);
                        r_shift <= in_data[14:6];
                        r_frac  <= in_data[5:0];
                        r_bcd   <= '0;
                        r_step  <= '0;
                    end
                end
                CONV: begin
                    r_bcd   <= 12'({w_bcd_adj, r_shift[8]});
                    r_shift <= {r_shift[7:0], 1'b0};
                    r_step  <= r_step + 4'd1;
                end
                FRAC: begin
                    r_tenth  <= 4'(w_frac_q / 7'd10);
                    r_hundth <= 4'(w_frac_q % 7'd10);
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------- display registers
    always_comb begin
        w_dn_neg     = r_disp_neg;
        w_dn_hund    = r_disp_hund;
        w_dn_tens    = r_disp_tens;
        w_dn_units   = r_disp_units;
        w_dn_tenth   = r_disp_tenth;
        w_dn_hundth  = r_disp_hundth;
        w_dn_blank_h = r_disp_blank_h;
        w_dn_blank_t = r_disp_blank_t;
        if (r_state == COMMIT) begin
            w_dn_neg    = r_neg;
            w_dn_hund   = r_bcd[11:8];
            w_dn_tens   = r_bcd[7:4];
            w_dn_units  = r_bcd[3:0];
            w_dn_tenth  = r_tenth;
            w_dn_hundth = r_hundth;
`ifdef SEG_LEADING_ZERO_BLANK_EN
            w_dn_blank_h = (r_bcd[11:8] == 4'd0);
            w_dn_blank_t = (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
`else
            w_dn_blank_h = 1'b0;
            w_dn_blank_t = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp_neg     <= 1'b0;
            r_disp_hund    <= 4'd0;
            r_disp_tens    <= 4'd0;
            r_disp_units   <= 4'd0;
            r_disp_tenth   <= 4'd0;
            r_disp_hundth  <= 4'd0;
            r_disp_blank_h <= 1'b1;
            r_disp_blank_t <= 1'b1;
        end else begin
            r_disp_neg     <= w_dn_neg;
            r_disp_hund    <= w_dn_hund;
            r_disp_tens    <= w_dn_tens;
            r_disp_units   <= w_dn_units;
            r_disp_tenth   <= w_dn_tenth;
            r_disp_hundth  <= w_dn_hundth;
            r_disp_blank_h <= w_dn_blank_h;
            r_disp_blank_t <= w_dn_blank_t;
        end
    end

    // ---------------------------------------------------------------- scan
    assign w_wrap = (r_div == c_DIV_MAX);

    always_comb begin
        w_pos_next = r_pos;
        if (w_wrap) begin
            w_pos_next = (r_pos == POS_HUNDTH) ? POS_SIGN : (r_pos - 3'd1);
        end
    end

    // Mux looks ahead at next position and next display contents so a commit
    // shows up on seg in the very next cycle.
    always_comb begin
        w_mux_digit = 4'd0;
        w_mux_blank = 1'b1;
        case (w_pos_next)
            POS_SIGN:   begin w_mux_digit = DIGIT_MINUS; w_mux_blank = ~w_dn_neg;    end
            POS_HUND:   begin w_mux_digit = w_dn_hund;   w_mux_blank = w_dn_blank_h; end
            POS_TENS:   begin w_mux_digit = w_dn_tens;   w_mux_blank = w_dn_blank_t; end
            POS_UNITS:  begin w_mux_digit = w_dn_units;  w_mux_blank = 1'b0;         end
            POS_TENTH:  begin w_mux_digit = w_dn_tenth;  w_mux_blank = 1'b0;         end
            POS_HUNDTH: begin w_mux_digit = w_dn_hundth; w_mux_blank = 1'b0;         end
            default:    ;
        endcase
    end

    seg_digit_enc u_digit_enc (
        .digit (w_mux_digit),
        .blank (w_mux_blank),
        .seg   (w_enc_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
            r_pos <= POS_SIGN;
            r_an  <= 6'b011111;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_div <= w_wrap ? '0 : (r_div + c_DIV_ONE);
            r_pos <= w_pos_next;
            r_an  <= ~(6'd1 << w_pos_next);
            r_seg <= w_enc_seg;
            r_dp  <= (w_pos_next != POS_UNITS);
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
`default_nettype wire

// File: doc/seg_display_ctrl.md
# seg_display_ctrl

Sequencing controller for the calculator's result display. It accepts one 16-bit sign-magnitude Q9.6 result per valid/ready handshake and converts it to six decimal display characters over a fixed multi-cycle sequence: a serial double-dabble for the integer part and one scaling cycle for the fraction. It then time-multiplexes those characters onto a shared active-low 7-segment bus with one-hot anode strobes. It sits between the ALU result register and the board's 6-digit multiplexed display.

## Interface
- SCAN_DIV, 50000: clock cycles each digit is lit; legal range is 2 or more.
- clk, input, 1: the single clock. All logic is rising-edge.
- rst, input, 1: reset, synchronous and active-high.
- in_data, input, 16: the value to display. [15] is the sign, [14:6] the integer magnitude, [5:0] the fraction in 1/64 units.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: high only in IDLE. A transfer occurs when in_valid and in_ready are both high.
- busy, output, 1: high while a conversion is in progress.
- an, output, 6: anode enables, active-low, one-hot. [5] is sign, [4] hundreds, [3] tens, [2] units, [1] tenths, [0] hundredths.
- seg, output, 7: segments gfedcba, active-low.
- dp, output, 1: decimal point, active-low. Lit only when an[2] is active.

## Operation
- States and transitions:
  - IDLE to CONV on a transfer. The transfer latches in_data, clears the BCD registers and sets the step counter to 0.
  - CONV performs 9 double-dabble steps over [14:6]. Each step adds 3 to any BCD nibble ≥5, then shifts left by one. After step 9 it goes to FRAC.
  - FRAC computes frac_q = ([5:0] × 100) >> 6 (truncating, 7-bit result, 0–98), splits it into tenths and hundredths, then goes to COMMIT.
  - COMMIT copies all digits and the sign into the display registers atomically, then returns to IDLE.
- The display registers change only in COMMIT, so the displayed value never tears.
- in_valid is ignored outside IDLE. No input is buffered.
- Sign character:
  - '-' (7'b0111111) when [15]=1 and the magnitude is nonzero.
  - Blank otherwise; negative zero displays unsigned.
- Digit encoding (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Blank is 1111111.
- Scan:
  - A free-running divider counts 0 to SCAN_DIV-1. At wrap, the position advances 5→4→…→0→5.
  - The scan never stops, including during conversion.
- Reset values:
  - in_ready=1, busy=0, state IDLE.
  - Display registers hold "+0.00": sign, hundreds and tens blank.
  - Scan position 5, divider 0, an=6'b011111, seg=7'b1111111 (blank sign), dp=1.
- Reset mid-conversion aborts the conversion. The partial result is discarded and the display returns to the reset contents.

## Timing
- Accepting edge E0. The CONV steps occur at E1–E9, FRAC at E10 and COMMIT at E11.
- New digits reach seg from the cycle after E11, in whichever slot is then active.
- busy is high from the cycle after E0 through the cycle ending at E11.
- in_ready is low during the same window and high again after E11. Back-to-back transfers are therefore 12 cycles apart.
- an, seg and dp are registered. All three change together, on the edge where the divider wraps.
- Every anode is low for exactly SCAN_DIV cycles per 6·SCAN_DIV-cycle frame.

## Configuration
- SEG_LEADING_ZERO_BLANK_EN:
  - When defined, hundreds is blanked if it is 0. Tens is blanked if both hundreds and tens are 0. Units is never blanked.
  - When undefined, all digits are always shown, e.g. "+000.00" is displayed as " 000.00".

## Structure
- Package disp_pkg holds:
  - The state enum (IDLE, CONV, FRAC, COMMIT).
  - The SEG_BLANK and SEG_MINUS constants.
  - The anode position localparams.
  - The digit-to-segment encoding function.
- Sub-module seg_digit_enc is combinational: a 4-bit digit plus a blank flag in, active-low 7-bit seg out. It is instantiated once on the scan mux output.

## Test plan
- Reset, then idle for 6·SCAN_DIV cycles with SCAN_DIV=4 → an cycles 011111, 101111 … 111110 every 4 cycles; the display shows blank, blank, blank, "0", "0", "0", and dp is low only on an[2].
- Send 0x0320 → in_ready is low for 12 cycles; then the display shows " 12.50" with hundreds blank.
- Send 0xBFF0 → "-255.75", with the sign slot showing 0111111.
- Send 0x7FFF → "511.98". Send 0x8000 → sign blank and "0.00".
- Hold in_valid high with 0x0040 and then 0x0080 back-to-back → only the first is accepted before E11; the second is accepted in the cycle after E11 and "2.00" appears.
- Assert rst at E5 after sending 0x3FC0 → state is IDLE, the display shows reset contents, and 255 never appears.
